eig_block_scheduler: RTL and testbench
======================================

EIG_BLOCK_SCHEDULER -- requirements
Module: eig_block_scheduler

Interface
REQ-001 Parameter DATA_W, 16, width of one matrix element and of each eigenvalue part.
REQ-002 Parameter TIMEOUT_CYC, 64, WAIT-state cycle limit; used only when the timeout feature is compiled in.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port clk, input, 1, rising-edge clock.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port start, input, 1, single-cycle request to process a_new.
REQ-007 Port a_new, input, 16*DATA_W, 4x4 matrix, row-major, element k = row*4+col at bits [k*DATA_W +: DATA_W].
REQ-008 Ports sol_x11, sol_x12, sol_x21, sol_x22, output, DATA_W each, 2x2 block driven to the shared solver.
REQ-009 Port sol_start, output, 1, one-cycle solver launch pulse.
REQ-010 Ports sol_done, sol_eig_reel, sol_eig_comp, input, 1/DATA_W/DATA_W, solver completion and results.
REQ-011 Ports eig_reel_1..3 and eig_comp_1..3, output, DATA_W each, per-block results.
REQ-012 Port blk_valid, output, 3, bit i set when block i+1 was solved; blk_err, output, 3, bit i set on timeout.
REQ-013 Port busy, output, 1; port done, output, 1, one-cycle completion pulse.

Function
REQ-014 Block i (0..2) SHALL be the window rows/cols i..i+1; its subdiagonal is element 4*(i+1)+i (elements 4, 9, 14).
REQ-015 FSM states SHALL be IDLE, SCAN, ISSUE, WAIT, DONE.
REQ-016 In IDLE, start=1 SHALL latch a_new, set idx=0, clear blk_valid, blk_err and all eig outputs, and go to SCAN; busy=1 in every state except IDLE.
REQ-017 start while busy=1 SHALL be ignored.
REQ-018 In SCAN, a nonzero subdiagonal SHALL go to ISSUE; a zero subdiagonal SHALL leave the block's outputs zero, then go to DONE if idx=2, else increment idx and stay in SCAN.
REQ-019 In ISSUE, sol_start SHALL be 1 for exactly one cycle; sol_x** SHALL be held stable from ISSUE through the end of WAIT; the next state is WAIT.
REQ-020 In WAIT, sol_done=1 SHALL capture sol_eig_reel/comp into block idx and set blk_valid[idx]; the FSM then goes to DONE if idx=2, else to SCAN with idx+1.
REQ-021 sol_done outside WAIT SHALL be ignored.
REQ-022 Latency SHALL be: done high at cycle 1 + sum over blocks (1 if skipped, 2+L if issued), where start is cycle 0 and L is the solver latency from sol_start to sol_done.
REQ-023 DONE SHALL pulse done for one cycle, return to IDLE, and hold results until the next accepted start.
REQ-024 Subdiagonal comparison SHALL be an exact compare of all DATA_W bits against zero.

Reset
REQ-025 rst SHALL, at any time including mid-WAIT, force IDLE, idx=0, and zero on all outputs, including sol_start.

Configuration
REQ-026 With EIG_SCHED_TIMEOUT_EN defined, a counter SHALL run in WAIT; reaching TIMEOUT_CYC cycles without sol_done SHALL set blk_err[idx], leave the block's results zero, and advance as in REQ-020.
REQ-027 If sol_done and the timeout occur in the same cycle, sol_done SHALL win.
REQ-028 Without EIG_SCHED_TIMEOUT_EN, WAIT SHALL wait indefinitely and blk_err SHALL be tied to zero.

Structure
REQ-029 Package eig_sched_pkg SHALL hold the state enum, DATA_W default, and subdiagonal element indices {4, 9, 14}.
REQ-030 Sub-module eig_blk_extract SHALL combinationally select the four window elements for a given idx; the solver itself is external.

Verification
REQ-031 All subdiagonals zero, start at cycle 0 -> no sol_start, done at cycle 4, blk_valid=000.
REQ-032 All nonzero, solver model L=3 returning reel=0x0100*(i+1), comp=0x0080 -> three sol_start pulses, done at cycle 16, blk_valid=111, eig_reel_2=0x0200.
REQ-033 Only element 9 nonzero -> one sol_start carrying elements 5, 6, 9, 10; blk_valid=010.
REQ-034 With EIG_SCHED_TIMEOUT_EN and TIMEOUT_CYC=8, the solver never answers block 1 -> blk_err=010, blk_valid=101, done asserted.
REQ-035 rst during WAIT of block 2, then start a second time -> outputs zero after reset, and the second start runs cleanly from block 1.
REQ-036 start pulsed while busy -> no restart, results match the first matrix.

Source files
------------

// File: rtl/eig_sched_pkg.sv
// Shared types and constants for the eigenvalue block scheduler.
package eig_sched_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int N_BLK      = 3;

  // Flat element index of each block's subdiagonal in the row-major 4x4
  localparam int SUB_IDX [N_BLK] = '{4, 9, 14};

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  function automatic int elem_idx(input int blk, input int r, input int c);
    return (blk + r) * 4 + blk + c;
  endfunction

endpackage

// File: rtl/eig_blk_extract.sv
// Selects the 2x2 diagonal window for block idx out of a 4x4 matrix.
module eig_blk_extract
  import eig_sched_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [16*DATA_W-1:0] mat,
  input  logic [1:0]           idx,
  output logic [DATA_W-1:0]    x11,
  output logic [DATA_W-1:0]    x12,
  output logic [DATA_W-1:0]    x21,
  output logic [DATA_W-1:0]    x22
);

  always_comb begin
    x11 = '0;
    x12 = '0;
    x21 = '0;
    x22 = '0;
    for (int b = 0; b < N_BLK; b++) begin
      if (idx == 2'(b)) begin
        x11 = mat[elem_idx(b, 0, 0)*DATA_W +: DATA_W];
        x12 = mat[elem_idx(b, 0, 1)*DATA_W +: DATA_W];
        x21 = mat[SUB_IDX[b]*DATA_W +: DATA_W];
        x22 = mat[elem_idx(b, 1, 1)*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/eig_block_scheduler.sv
// Walks the three 2x2 diagonal blocks of a 4x4 matrix, launching the shared
// solver on each block with a nonzero subdiagonal. Option: EIG_SCHED_TIMEOUT_EN.
module eig_block_scheduler
  import eig_sched_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [16*DATA_W-1:0] a_new,
  output logic [DATA_W-1:0]    sol_x11,
  output logic [DATA_W-1:0]    sol_x12,
  output logic [DATA_W-1:0]    sol_x21,
  output logic [DATA_W-1:0]    sol_x22,
  output logic                 sol_start,
  input  logic                 sol_done,
  input  logic [DATA_W-1:0]    sol_eig_reel,
  input  logic [DATA_W-1:0]    sol_eig_comp,
  output logic [DATA_W-1:0]    eig_reel_1,
  output logic [DATA_W-1:0]    eig_reel_2,
  output logic [DATA_W-1:0]    eig_reel_3,
  output logic [DATA_W-1:0]    eig_comp_1,
  output logic [DATA_W-1:0]    eig_comp_2,
  output logic [DATA_W-1:0]    eig_comp_3,
  output logic [2:0]           blk_valid,
  output logic [2:0]           blk_err,
  output logic                 busy,
  output logic                 done
);

`ifdef EIG_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int TCW = $clog2(TIMEOUT_CYC + 1);

  state_t                          state;
  logic [1:0]                      idx;
  logic [16*DATA_W-1:0]            mat;
  logic [N_BLK-1:0][DATA_W-1:0]    reel_q;
  logic [N_BLK-1:0][DATA_W-1:0]    comp_q;
  logic [2:0]                      err_q;
  logic [TCW-1:0]                  tcnt;
  logic [DATA_W-1:0]               w11;
  logic [DATA_W-1:0]               w12;
  logic [DATA_W-1:0]               w21;
  logic [DATA_W-1:0]               w22;
  logic                            last;
  logic                            timeout;

  eig_blk_extract #(
    .DATA_W(DATA_W)
  ) u_extract (
    .mat(mat),
    .idx(idx),
    .x11(w11),
    .x12(w12),
    .x21(w21),
    .x22(w22)
  );

  assign last    = (idx == 2'(N_BLK - 1));
  assign timeout = TO_EN && (tcnt == TCW'(TIMEOUT_CYC - 1));

  // Registered launch window and outputs; WAIT holds sol_x* untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      mat       <= '0;
      reel_q    <= '0;
      comp_q    <= '0;
      err_q     <= '0;
      tcnt      <= '0;
      blk_valid <= '0;
      sol_x11   <= '0;
      sol_x12   <= '0;
      sol_x21   <= '0;
      sol_x22   <= '0;
      sol_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      sol_start <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            mat       <= a_new;
            idx       <= '0;
            blk_valid <= '0;
            err_q     <= '0;
            reel_q    <= '0;
            comp_q    <= '0;
            busy      <= 1'b1;
            state     <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w21 != '0) begin
            sol_x11   <= w11;
            sol_x12   <= w12;
            sol_x21   <= w21;
            sol_x22   <= w22;
            sol_start <= 1'b1;
            state     <= S_ISSUE;
          end else if (last) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            idx <= idx + 2'd1;
          end
        end
        S_ISSUE: begin
          tcnt  <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (sol_done || timeout) begin
            // A late answer in the timeout cycle still counts as success
            if (sol_done) begin
              reel_q[idx]    <= sol_eig_reel;
              comp_q[idx]    <= sol_eig_comp;
              blk_valid[idx] <= 1'b1;
            end else begin
              err_q[idx] <= 1'b1;
            end
            if (last) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx   <= idx + 2'd1;
              state <= S_SCAN;
            end
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign blk_err    = TO_EN ? err_q : 3'b000;
  assign eig_reel_1 = reel_q[0];
  assign eig_reel_2 = reel_q[1];
  assign eig_reel_3 = reel_q[2];
  assign eig_comp_1 = comp_q[0];
  assign eig_comp_2 = comp_q[1];
  assign eig_comp_3 = comp_q[2];

endmodule

// File: tb/tb_eig_block_scheduler.sv
// Randomized bench for eig_block_scheduler with a behavioural solver and
// a per-matrix reference model of latency and results.
module tb_eig_block_scheduler;

  localparam int DW     = 16;
  localparam int TO_CYC = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [16*DW-1:0] a_new;
  logic [DW-1:0]    sol_x11;
  logic [DW-1:0]    sol_x12;
  logic [DW-1:0]    sol_x21;
  logic [DW-1:0]    sol_x22;
  logic             sol_start;
  logic             sol_done;
  logic [DW-1:0]    sol_eig_reel;
  logic [DW-1:0]    sol_eig_comp;
  logic [DW-1:0]    eig_reel_1;
  logic [DW-1:0]    eig_reel_2;
  logic [DW-1:0]    eig_reel_3;
  logic [DW-1:0]    eig_comp_1;
  logic [DW-1:0]    eig_comp_2;
  logic [DW-1:0]    eig_comp_3;
  logic [2:0]       blk_valid;
  logic [2:0]       blk_err;
  logic             busy;
  logic             done;

  eig_block_scheduler #(
    .DATA_W(DW),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a_new(a_new),
    .sol_x11(sol_x11),
    .sol_x12(sol_x12),
    .sol_x21(sol_x21),
    .sol_x22(sol_x22),
    .sol_start(sol_start),
    .sol_done(sol_done),
    .sol_eig_reel(sol_eig_reel),
    .sol_eig_comp(sol_eig_comp),
    .eig_reel_1(eig_reel_1),
    .eig_reel_2(eig_reel_2),
    .eig_reel_3(eig_reel_3),
    .eig_comp_1(eig_comp_1),
    .eig_comp_2(eig_comp_2),
    .eig_comp_3(eig_comp_3),
    .blk_valid(blk_valid),
    .blk_err(blk_err),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [16*DW-1:0] cur_mat;
  int               lat [3];
  logic [DW-1:0]    rv [3];
  logic [DW-1:0]    cv [3];
  bit               mute [3];
  int               nxt;
  int               ss_cnt;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] elem(input logic [16*DW-1:0] m,
                                         input int k);
    return m[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] subd(input logic [16*DW-1:0] m,
                                         input int b);
    return elem(m, (b + 1) * 4 + b);
  endfunction

  function automatic logic [16*DW-1:0] rand_mat();
    logic [16*DW-1:0] m;
    for (int k = 0; k < 16; k++) m[k*DW +: DW] = DW'($urandom);
    return m;
  endfunction

  function automatic logic [16*DW-1:0] set_sub(input logic [16*DW-1:0] m,
                                               input int b, input bit nz);
    logic [16*DW-1:0] r;
    r = m;
    r[((b + 1) * 4 + b)*DW +: DW] = nz ? DW'($urandom_range(1, 65535)) : '0;
    return r;
  endfunction

  always @(negedge clk) if (sol_start) ss_cnt++;

  // Behavioural solver: answers each launch after lat[b] cycles, and drops a
  // junk sol_done pulse into the launch cycle when latency allows it
  initial begin
    int b;
    sol_done     = 1'b0;
    sol_eig_reel = '0;
    sol_eig_comp = '0;
    forever begin
      @(negedge clk);
      if (sol_start && !rst) begin
        b = nxt;
        while (b < 3 && subd(cur_mat, b) == '0) b++;
        nxt = b + 1;
        if (b > 2) check("sol_blk", 64'(b), 64'd2);
        else begin
          check($sformatf("win%0d_x11", b), sol_x11, elem(cur_mat, b*4 + b));
          check($sformatf("win%0d_x12", b), sol_x12, elem(cur_mat, b*4 + b + 1));
          check($sformatf("win%0d_x21", b), sol_x21, elem(cur_mat, (b+1)*4 + b));
          check($sformatf("win%0d_x22", b), sol_x22, elem(cur_mat, (b+1)*4 + b + 1));
          if (!mute[b]) begin
            if (lat[b] >= 2) begin
              sol_done     = 1'b1;
              sol_eig_reel = DW'($urandom);
              sol_eig_comp = DW'($urandom);
            end
            repeat (lat[b]) begin
              @(negedge clk);
              sol_done = 1'b0;
            end
            check($sformatf("hold%0d_x21", b), sol_x21, elem(cur_mat, (b+1)*4 + b));
            sol_done     = 1'b1;
            sol_eig_reel = rv[b];
            sol_eig_comp = cv[b];
            @(negedge clk);
            sol_done = 1'b0;
          end
        end
      end
    end
  end

  task automatic run(input logic [16*DW-1:0] m, input bit poke);
    int            exp_cyc;
    int            nis;
    int            n;
    logic [2:0]    ev;
    logic [2:0]    ee;
    logic [DW-1:0] er [3];
    logic [DW-1:0] ec [3];
    exp_cyc = 1;
    nis     = 0;
    ev      = '0;
    ee      = '0;
    for (int b = 0; b < 3; b++) begin
      er[b] = '0;
      ec[b] = '0;
      if (subd(m, b) == '0) exp_cyc += 1;
      else begin
        nis++;
        if (mute[b]) begin
          exp_cyc += 2 + TO_CYC;
          ee[b] = 1'b1;
        end else begin
          exp_cyc += 2 + lat[b];
          ev[b] = 1'b1;
          er[b] = rv[b];
          ec[b] = cv[b];
        end
      end
    end
    cur_mat = m;
    nxt     = 0;
    ss_cnt  = 0;
    @(negedge clk);
    a_new = m;
    start = 1'b1;
    @(negedge clk);
    n = 1;
    while (!done && n < exp_cyc + 20) begin
      start = (poke && n == 2);
      if (start) a_new = rand_mat();
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    check("done_cycle", 64'(n), 64'(exp_cyc));
    check("done", done, 1'b1);
    check("busy_at_done", busy, 1'b1);
    check("blk_valid", blk_valid, ev);
    check("blk_err", blk_err, ee);
    check("eig_reel_1", eig_reel_1, er[0]);
    check("eig_reel_2", eig_reel_2, er[1]);
    check("eig_reel_3", eig_reel_3, er[2]);
    check("eig_comp_1", eig_comp_1, ec[0]);
    check("eig_comp_2", eig_comp_2, ec[1]);
    check("eig_comp_3", eig_comp_3, ec[2]);
    check("sol_start_cnt", 64'(ss_cnt), 64'(nis));
    @(negedge clk);
    check("done_pulse", done, 1'b0);
    check("busy_idle", busy, 1'b0);
    check("hold_reel_1", eig_reel_1, er[0]);
    check("hold_valid", blk_valid, ev);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_sol_start"}, sol_start, 1'b0);
    check({tag, "_valid"}, blk_valid, 3'b000);
    check({tag, "_err"}, blk_err, 3'b000);
    check({tag, "_reel_1"}, eig_reel_1, '0);
    check({tag, "_comp_1"}, eig_comp_1, '0);
    check({tag, "_x21"}, sol_x21, '0);
  endtask

  initial begin
    logic [16*DW-1:0] m;
    int               n;
    rst   = 1'b1;
    start = 1'b0;
    a_new = '0;
    for (int b = 0; b < 3; b++) begin
      mute[b] = 1'b0;
      lat[b]  = 1;
      rv[b]   = '0;
      cv[b]   = '0;
    end
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // All subdiagonals zero
    m = rand_mat();
    for (int b = 0; b < 3; b++) m = set_sub(m, b, 1'b0);
    run(m, 1'b0);

    // All issued, fixed latency 3
    m = rand_mat();
    for (int b = 0; b < 3; b++) begin
      m      = set_sub(m, b, 1'b1);
      lat[b] = 3;
      rv[b]  = DW'(16'h0100 * (b + 1));
      cv[b]  = 16'h0080;
    end
    run(m, 1'b0);
    check("eig_reel_2_fixed", eig_reel_2, 16'h0200);

    // Only the middle subdiagonal nonzero
    m = rand_mat();
    m = set_sub(m, 0, 1'b0);
    m = set_sub(m, 1, 1'b1);
    m = set_sub(m, 2, 1'b0);
    run(m, 1'b0);

    // Reset while waiting on the second block, then a clean rerun
    m = rand_mat();
    for (int b = 0; b < 3; b++) begin
      m      = set_sub(m, b, 1'b1);
      lat[b] = $urandom_range(1, 4);
    end
    mute[1] = 1'b1;
    cur_mat = m;
    nxt     = 0;
    ss_cnt  = 0;
    @(negedge clk);
    a_new = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n     = 0;
    while (ss_cnt < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait_blk2", 64'(ss_cnt), 64'd2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    rst     = 1'b0;
    mute[1] = 1'b0;
    m = rand_mat();
    for (int b = 0; b < 3; b++) m = set_sub(m, b, 1'b1);
    run(m, 1'b0);

`ifdef EIG_SCHED_TIMEOUT_EN
    m = rand_mat();
    for (int b = 0; b < 3; b++) m = set_sub(m, b, 1'b1);
    mute[1] = 1'b1;
    run(m, 1'b0);
    mute[1] = 1'b0;
`endif

    // Random matrices, latencies and results, with start pokes while busy
    for (int r = 0; r < 24; r++) begin
      m = rand_mat();
      for (int b = 0; b < 3; b++) begin
        m      = set_sub(m, b, 1'($urandom_range(0, 1)));
        lat[b] = $urandom_range(1, 5);
        rv[b]  = DW'($urandom);
        cv[b]  = DW'($urandom);
      end
      run(m, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
